// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer.
//   seq_state_t        : sequencer state encoding (BOOT, RUN, HALTED)
//   ADDR_WIDTH_DEFAULT : default fetch-address width
package pc_seq_pkg;

    localparam int ADDR_WIDTH_DEFAULT = 12;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } seq_state_t;

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// ret_stack: LIFO of return addresses for the PC sequencer.
// Ports:
//   clk, reset     : clock, synchronous active-low reset (clears occupancy only)
//   push, pop      : push push_data / discard top entry; pop wins if both are set
//   push_data      : address to store
//   pop_data       : current top-of-stack entry (valid when !empty)
//   count          : occupancy, 0..DEPTH
//   full, empty    : occupancy status
// A push while full or a pop while empty is ignored; the caller owns the
// error reporting.
module ret_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         push_data,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    count_reg;
    logic [PW-1:0]    wr_idx;
    logic [PW-1:0]    rd_idx;
    logic             wr_en;
    logic             rd_en;

    assign full   = (count_reg == CW'(DEPTH));
    assign empty  = (count_reg == '0);
    assign count  = count_reg;

    // The next free slot is the occupancy itself; the top sits one below.
    assign wr_idx = count_reg[PW-1:0];
    assign rd_idx = wr_idx - PW'(1);

    assign rd_en  = pop && !empty;
    assign wr_en  = push && !full && !rd_en;

    // The top entry is read combinationally so a return can redirect the
    // PC on the same edge that it pops.
    assign pop_data = mem[rd_idx];

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (rd_en) begin
            count_reg <= count_reg - CW'(1);
        end else if (wr_en) begin
            count_reg <= count_reg + CW'(1);
        end
    end

    // Entry contents need no reset: occupancy alone defines what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: generates instruction fetch addresses.
// Ports:
//   clk, reset                  : clock, synchronous active-low reset
//   fetch_ready                 : memory accepted the current fetch
//   branch_taken/branch_target  : taken conditional branch
//   jump/jump_target            : unconditional jump
//   call/call_target            : subroutine call (pushes pc_out+1)
//   ret                         : subroutine return (pops into pc_out)
//   halt                        : stop fetching until reset
//   pc_out, fetch_valid         : fetch request
//   halted                      : sequencer is in HALTED
//   stack_count                 : return-stack occupancy
//   stack_overflow/underflow    : sticky stack error flags
// Next-PC priority in RUN: halt > ret > call > jump > branch > sequential.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DEFAULT,
    parameter int STACK_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           fetch_ready,
    input  logic                           branch_taken,
    input  logic [ADDR_WIDTH-1:0]          branch_target,
    input  logic                           jump,
    input  logic [ADDR_WIDTH-1:0]          jump_target,
    input  logic                           call,
    input  logic [ADDR_WIDTH-1:0]          call_target,
    input  logic                           ret,
    input  logic                           halt,
    output logic [ADDR_WIDTH-1:0]          pc_out,
    output logic                           fetch_valid,
    output logic                           halted,
    output logic [$clog2(STACK_DEPTH):0]   stack_count,
    output logic                           stack_overflow,
    output logic                           stack_underflow
);

    seq_state_t            state_reg, state_next;
    logic [ADDR_WIDTH-1:0] pc_reg, pc_next;
    logic                  ovf_reg, ovf_next;
    logic                  unf_reg, unf_next;

    logic                  stk_push, stk_pop;
    logic                  stk_full, stk_empty;
    logic [ADDR_WIDTH-1:0] stk_top;
    logic [ADDR_WIDTH-1:0] pc_inc;

    // Natural wrap at 2^ADDR_WIDTH; also the return address for a call.
    assign pc_inc = pc_reg + ADDR_WIDTH'(1);

    ret_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (ADDR_WIDTH)
    ) u_ret_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (pc_inc),
        .pop_data  (stk_top),
        .count     (stack_count),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= BOOT;
            pc_reg    <= '0;
            ovf_reg   <= 1'b0;
            unf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            ovf_reg   <= ovf_next;
            unf_reg   <= unf_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        ovf_next   = ovf_reg;
        unf_next   = unf_reg;
        stk_push   = 1'b0;
        stk_pop    = 1'b0;
        case (state_reg)
            BOOT: begin
                state_next = RUN;
            end
            RUN: begin
                if (halt) begin
                    state_next = HALTED;
                end else if (ret) begin
                    // An empty-stack return holds the PC and just flags it.
                    if (stk_empty) begin
                        unf_next = 1'b1;
                    end else begin
                        stk_pop = 1'b1;
                        pc_next = stk_top;
                    end
                end else if (call) begin
                    // The call still redirects when the return cannot be saved.
                    pc_next = call_target;
                    if (stk_full) begin
                        ovf_next = 1'b1;
                    end else begin
                        stk_push = 1'b1;
                    end
                end else if (jump) begin
                    pc_next = jump_target;
                end else if (branch_taken) begin
                    pc_next = branch_target;
                end else if (fetch_ready) begin
                    pc_next = pc_inc;
                end
            end
            HALTED: begin
                state_next = HALTED;
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    assign pc_out          = pc_reg;
    assign fetch_valid     = (state_reg == RUN);
    assign halted          = (state_reg == HALTED);
    assign stack_overflow  = ovf_reg;
    assign stack_underflow = unf_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: table of per-cycle stimulus with hand-derived
// expected outputs (state after the edge), checked through a scoreboard
// queue, followed by a hand-written mid-operation reset sequence.
module tb_pc_sequencer;

    localparam int AW = 12;
    localparam int SD = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          fetch_ready;
    logic          branch_taken;
    logic [AW-1:0] branch_target;
    logic          jump;
    logic [AW-1:0] jump_target;
    logic          call;
    logic [AW-1:0] call_target;
    logic          ret;
    logic          halt;
    logic [AW-1:0] pc_out;
    logic          fetch_valid;
    logic          halted;
    logic [2:0]    stack_count;
    logic          stack_overflow;
    logic          stack_underflow;

    always #5 clk = ~clk;

    pc_sequencer #(.ADDR_WIDTH(AW), .STACK_DEPTH(SD)) dut (
        .clk             (clk),
        .reset           (reset),
        .fetch_ready     (fetch_ready),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .jump            (jump),
        .jump_target     (jump_target),
        .call            (call),
        .call_target     (call_target),
        .ret             (ret),
        .halt            (halt),
        .pc_out          (pc_out),
        .fetch_valid     (fetch_valid),
        .halted          (halted),
        .stack_count     (stack_count),
        .stack_overflow  (stack_overflow),
        .stack_underflow (stack_underflow)
    );

    typedef struct {
        logic          rst_n;
        logic          fr;
        logic          hl;
        logic          rt;
        logic          cl;
        logic [AW-1:0] ct;
        logic          jp;
        logic [AW-1:0] jt;
        logic          br;
        logic [AW-1:0] bt;
        logic [AW-1:0] epc;
        logic          efv;
        logic          ehd;
        logic [2:0]    ecnt;
        logic          eovf;
        logic          eunf;
    } vec_t;

    typedef struct {
        logic [AW-1:0] pc;
        logic          fv;
        logic          hd;
        logic [2:0]    cnt;
        logic          ovf;
        logic          unf;
    } exp_t;

    vec_t tbl[$];
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;

    function automatic vec_t mk(logic rst_n, logic fr, logic hl, logic rt,
                                logic cl, logic [AW-1:0] ct, logic jp, logic [AW-1:0] jt,
                                logic br, logic [AW-1:0] bt, logic [AW-1:0] epc,
                                logic efv, logic ehd, logic [2:0] ecnt, logic eovf, logic eunf);
        vec_t v;
        v.rst_n = rst_n; v.fr = fr; v.hl = hl; v.rt = rt;
        v.cl = cl; v.ct = ct; v.jp = jp; v.jt = jt; v.br = br; v.bt = bt;
        v.epc = epc; v.efv = efv; v.ehd = ehd; v.ecnt = ecnt; v.eovf = eovf; v.eunf = eunf;
        return v;
    endfunction

    // Drive one cycle of stimulus, queue its expectation, then check the
    // outputs 1 time unit after the edge that consumes it.
    task automatic step(input vec_t v, input string tag);
        exp_t e;
        exp_t got;
        reset         = v.rst_n;
        fetch_ready   = v.fr;
        halt          = v.hl;
        ret           = v.rt;
        call          = v.cl;
        call_target   = v.ct;
        jump          = v.jp;
        jump_target   = v.jt;
        branch_taken  = v.br;
        branch_target = v.bt;
        e.pc = v.epc; e.fv = v.efv; e.hd = v.ehd;
        e.cnt = v.ecnt; e.ovf = v.eovf; e.unf = v.eunf;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        got.pc = pc_out; got.fv = fetch_valid; got.hd = halted;
        got.cnt = stack_count; got.ovf = stack_overflow; got.unf = stack_underflow;
        checks++;
        if (got.pc !== e.pc || got.fv !== e.fv || got.hd !== e.hd ||
            got.cnt !== e.cnt || got.ovf !== e.ovf || got.unf !== e.unf) begin
            errors++;
            $display("FAIL %s#%0d: got pc=%h fv=%b hd=%b cnt=%0d ovf=%b unf=%b, want pc=%h fv=%b hd=%b cnt=%0d ovf=%b unf=%b",
                     tag, txn, got.pc, got.fv, got.hd, got.cnt, got.ovf, got.unf,
                     e.pc, e.fv, e.hd, e.cnt, e.ovf, e.unf);
        end else begin
            $display("ok   %s#%0d: pc=%h fv=%b hd=%b cnt=%0d ovf=%b unf=%b",
                     tag, txn, got.pc, got.fv, got.hd, got.cnt, got.ovf, got.unf);
        end
        txn++;
    endtask

    initial begin
        reset = 1'b0; fetch_ready = 1'b0; halt = 1'b0; ret = 1'b0; call = 1'b0;
        jump = 1'b0; branch_taken = 1'b0;
        call_target = '0; jump_target = '0; branch_target = '0;

        //            rst fr hl rt cl ct      jp jt      br bt        epc     fv hd cnt ovf unf
        // Reset, BOOT, then sequential fetch
        tbl.push_back(mk(0, 1, 0, 0, 0, 12'h000, 0, 12'h000, 0, 12'h000, 12'h000, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 12'h000, 0, 12'h000, 0, 12'h000, 12'h000, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 12'h000, 0, 12'h000, 0, 12'h000, 12'h001, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 12'h000, 0, 12'h000, 0, 12'h000, 12'h002, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 12'h000, 0, 12'h000, 0, 12'h000, 12'h003, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 12'h000, 0, 12'h000, 0, 12'h000, 12'h004, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 12'h000, 0, 12'h000, 0, 12'h000, 12'h005, 1, 0, 0, 0, 0));
        // Stall holds, redirects ignore fetch_ready, jump beats branch
        tbl.push_back(mk(1, 0, 0, 0, 0, 12'h000, 0, 12'h000, 0, 12'h000, 12'h005, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 12'h000, 0, 12'h000, 0, 12'h000, 12'h005, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 12'h000, 0, 12'h000, 0, 12'h000, 12'h005, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 12'h000, 1, 12'h100, 0, 12'h000, 12'h100, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 12'h000, 0, 12'h000, 1, 12'h0F0, 12'h0F0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 12'h000, 1, 12'h0FF, 1, 12'h123, 12'h0FF, 1, 0, 0, 0, 0));
        // Address wrap
        tbl.push_back(mk(1, 0, 0, 0, 0, 12'h000, 1, 12'hFFE, 0, 12'h000, 12'hFFE, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 12'h000, 0, 12'h000, 0, 12'h000, 12'hFFF, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 12'h000, 0, 12'h000, 0, 12'h000, 12'h000, 1, 0, 0, 0, 0));
        // Nested call/return; call beats jump; ret beats call
        tbl.push_back(mk(1, 0, 0, 0, 0, 12'h000, 1, 12'h010, 0, 12'h000, 12'h010, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 12'h200, 0, 12'h000, 0, 12'h000, 12'h200, 1, 0, 1, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 12'h000, 0, 12'h000, 0, 12'h000, 12'h201, 1, 0, 1, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 12'h300, 1, 12'h555, 0, 12'h000, 12'h300, 1, 0, 2, 0, 0));
        tbl.push_back(mk(1, 1, 0, 1, 1, 12'h777, 0, 12'h000, 0, 12'h000, 12'h202, 1, 0, 1, 0, 0));
        tbl.push_back(mk(1, 1, 0, 1, 0, 12'h000, 0, 12'h000, 0, 12'h000, 12'h011, 1, 0, 0, 0, 0));
        // Fill stack, overflow, drain, underflow
        tbl.push_back(mk(1, 0, 0, 0, 1, 12'h400, 0, 12'h000, 0, 12'h000, 12'h400, 1, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 12'h500, 0, 12'h000, 0, 12'h000, 12'h500, 1, 0, 2, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 12'h600, 0, 12'h000, 0, 12'h000, 12'h600, 1, 0, 3, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 12'h700, 0, 12'h000, 0, 12'h000, 12'h700, 1, 0, 4, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 12'h800, 0, 12'h000, 0, 12'h000, 12'h800, 1, 0, 4, 1, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 12'h000, 0, 12'h000, 0, 12'h000, 12'h601, 1, 0, 3, 1, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 12'h000, 0, 12'h000, 0, 12'h000, 12'h501, 1, 0, 2, 1, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 12'h000, 0, 12'h000, 0, 12'h000, 12'h401, 1, 0, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 12'h000, 0, 12'h000, 0, 12'h000, 12'h012, 1, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 0, 1, 0, 12'h000, 0, 12'h000, 0, 12'h000, 12'h012, 1, 0, 0, 1, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 12'h000, 0, 12'h000, 0, 12'h000, 12'h013, 1, 0, 0, 1, 1));
        // Halt beats every redirect; HALTED ignores inputs; reset recovers
        tbl.push_back(mk(1, 0, 0, 0, 1, 12'h0A0, 0, 12'h000, 0, 12'h000, 12'h0A0, 1, 0, 1, 1, 1));
        tbl.push_back(mk(1, 1, 1, 1, 1, 12'h0C0, 1, 12'h080, 1, 12'h090, 12'h0A0, 0, 1, 1, 1, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 12'h000, 1, 12'h111, 0, 12'h000, 12'h0A0, 0, 1, 1, 1, 1));
        tbl.push_back(mk(1, 1, 0, 1, 1, 12'h0D0, 0, 12'h000, 0, 12'h000, 12'h0A0, 0, 1, 1, 1, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 12'h000, 1, 12'h222, 0, 12'h000, 12'h000, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 12'h000, 1, 12'h222, 0, 12'h000, 12'h000, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 12'h000, 0, 12'h000, 0, 12'h000, 12'h001, 1, 0, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], "tbl");
        end

        // Reset held two cycles over a live stack and a pending return,
        // then BOOT ignores the return and the stack proves empty.
        step(mk(1, 0, 0, 0, 1, 12'h3C0, 0, 12'h000, 0, 12'h000, 12'h3C0, 1, 0, 1, 0, 0), "rst");
        step(mk(1, 0, 0, 0, 1, 12'h3D0, 0, 12'h000, 0, 12'h000, 12'h3D0, 1, 0, 2, 0, 0), "rst");
        step(mk(0, 1, 0, 1, 0, 12'h000, 0, 12'h000, 0, 12'h000, 12'h000, 0, 0, 0, 0, 0), "rst");
        step(mk(0, 1, 0, 1, 0, 12'h000, 0, 12'h000, 0, 12'h000, 12'h000, 0, 0, 0, 0, 0), "rst");
        step(mk(1, 1, 0, 1, 0, 12'h000, 0, 12'h000, 0, 12'h000, 12'h000, 1, 0, 0, 0, 0), "rst");
        step(mk(1, 1, 0, 1, 0, 12'h000, 0, 12'h000, 0, 12'h000, 12'h000, 1, 0, 0, 0, 1), "rst");
        step(mk(1, 1, 0, 0, 0, 12'h000, 0, 12'h000, 0, 12'h000, 12'h001, 1, 0, 0, 0, 1), "rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter ADDR_WIDTH, default 12: width of every address port.
REQ-002 Parameter STACK_DEPTH, default 4: number of return-stack entries, power of two, minimum 2.
REQ-003 clk  input  1  rising-edge clock; single clock domain.
REQ-004 reset  input  1  reset, synchronous, active-low (0 = reset).
REQ-005 fetch_ready  input  1  instruction memory accepts the current fetch this cycle.
REQ-006 branch_taken  input  1  conditional branch resolved taken.
REQ-007 branch_target  input  ADDR_WIDTH  branch destination.
REQ-008 jump  input  1  unconditional jump request.
REQ-009 jump_target  input  ADDR_WIDTH  jump destination.
REQ-010 call  input  1  subroutine call request.
REQ-011 call_target  input  ADDR_WIDTH  call destination.
REQ-012 ret  input  1  subroutine return request.
REQ-013 halt  input  1  stop fetching.
REQ-014 pc_out  output  ADDR_WIDTH  current fetch address.
REQ-015 fetch_valid  output  1  pc_out is a valid fetch request.
REQ-016 halted  output  1  sequencer is in HALTED.
REQ-017 stack_count  output  $clog2(STACK_DEPTH)+1  return-stack occupancy.
REQ-018 stack_overflow  output  1  sticky: call made while stack full.
REQ-019 stack_underflow  output  1  sticky: ret made while stack empty.

Function
REQ-020 States BOOT, RUN, HALTED; BOOT -> RUN unconditionally after one cycle; RUN -> HALTED when halt=1; HALTED exits only through reset.
REQ-021 In BOOT and HALTED, fetch_valid=0, pc_out held, and all redirect inputs ignored.
REQ-022 In RUN, fetch_valid=1 every cycle.
REQ-023 Next-PC priority in RUN: halt > ret > call > jump > branch_taken > sequential.
REQ-024 Sequential: pc_out increments by 1 only when fetch_ready=1; it holds when fetch_ready=0.
REQ-025 Increment wraps modulo 2^ADDR_WIDTH (0xFFF -> 0x000 at default width); no flag is raised.
REQ-026 Redirects (ret/call/jump/branch) load pc_out on the next edge regardless of fetch_ready; an unaccepted fetch is abandoned.
REQ-027 jump and branch load their target; latency is one cycle from request to new pc_out.
REQ-028 call pushes pc_out+1 (wrapped) and loads call_target; if the stack is full, no push occurs, stack_overflow sets, and the load still happens.
REQ-029 ret pops the top entry into pc_out; if the stack is empty, pc_out holds, stack_underflow sets, and stack_count stays 0.
REQ-030 call and ret asserted together: ret wins, and the stack performs a pop only.
REQ-031 halt together with any redirect: halt wins, pc_out holds, and the stack is unchanged.
REQ-032 stack_count reflects a push or pop on the edge where it occurs; LIFO order is preserved across all entries.

Reset
REQ-033 When reset=0 at a rising edge: state=BOOT, pc_out=0, fetch_valid=0, halted=0, stack_count=0, stack_overflow=0, stack_underflow=0.
REQ-034 Reset asserted mid-operation (any state, any pending redirect) takes priority over all inputs; stack contents become don't-care.

Structure
REQ-035 Shared package pc_seq_pkg holds the state enum (BOOT, RUN, HALTED) and the ADDR_WIDTH default constant.
REQ-036 Return stack is one sub-module ret_stack (push, pop, data in/out, count, full, empty); sticky flags and next-PC muxing stay in pc_sequencer.

Verification
REQ-037 Reset release, fetch_ready=1 -> BOOT cycle with fetch_valid=0, then pc_out 0,1,2,3 on successive cycles with fetch_valid=1.
REQ-038 pc_out=0x005, fetch_ready=0 for 3 cycles -> pc_out stays 0x005; jump to 0x100 with fetch_ready=0 -> pc_out=0x100 next cycle.
REQ-039 From pc_out=0xFFE with fetch_ready=1 -> pc_out 0xFFF then 0x000, and no flags are set.
REQ-040 call 0x200 at pc 0x010, call 0x300 at pc 0x201, ret, ret -> pc_out 0x200, 0x300, 0x202, 0x011; stack_count 1,2,1,0.
REQ-041 5 calls with STACK_DEPTH=4 -> stack_overflow=1 and stack_count=4; then ret on an empty stack after 4 pops -> stack_underflow=1 and pc_out held.
REQ-042 halt with jump 0x080 in the same cycle -> halted=1, fetch_valid=0, pc unchanged; reset=0 one cycle -> all outputs return to their reset values.
